code_hold_decoder: RTL and testbench

Sequential counterpart to the team's 4-input priority encoder. Accepts a 3-bit encoded word {valid, idx[1:0]} over a valid/ready handshake and decodes it to a one-hot 4-bit output. Each decoded output is held asserted for a fixed number of cycles, which stretches pulses for indicator/LED drive. Sits downstream of the encoder, on the same clock.

---
 rtl/code_hold_decoder_pkg.sv | 24 ++
 rtl/code_hold_decoder_hold_timer.sv | 40 ++++
 rtl/code_hold_decoder.sv | 98 +++++++++
 tb/tb_code_hold_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/code_hold_decoder_pkg.sv
// Shared definitions for the priority-encoder / hold-decoder pair.
//   CODE_W, IDX_W, N_OUT, CODE_VALID_BIT : encoded word layout {valid, idx[1:0]}
//   state_e                               : decoder FSM states
//   decode_idx()                          : index to one-hot conversion
package code_hold_decoder_pkg;

    localparam int CODE_W         = 3;
    localparam int IDX_W          = 2;
    localparam int N_OUT          = 4;
    localparam int CODE_VALID_BIT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [N_OUT-1:0] decode_idx(input logic [IDX_W-1:0] idx);
        logic [N_OUT-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/code_hold_decoder_hold_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst : clock and asynchronous active-high reset
//   load     : reload the counter with HOLD_CYCLES-1
//   cnt_zero : counter currently equals zero
// The counter stops at zero; it only leaves zero through a load.
module code_hold_decoder_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic cnt_zero
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/code_hold_decoder.sv
// Decodes an encoded word {valid, idx[1:0]} to a one-hot output and holds it
// asserted for HOLD_CYCLES cycles (pulse stretching for indicator drive).
//   clk, rst   : clock and asynchronous active-high reset
//   in_valid   : a code is presented
//   in_ready   : block can accept a code this cycle (from state/counter only)
//   code       : bit2 = valid flag, bits1:0 = index
//   onehot     : registered decoded output, held while in HOLD
//   out_valid  : registered, high while onehot is nonzero
//   null_pulse : registered one-cycle pulse when a code with bit2=0 is accepted
//
// Handshake: a code is accepted at a rising edge where in_valid && in_ready.
// in_ready never depends on in_valid, and code is sampled only on acceptance.
module code_hold_decoder
    import code_hold_decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code,
    output logic [N_OUT-1:0]  onehot,
    output logic              out_valid,
    output logic              null_pulse
);

    state_e            state_q;
    state_e            state_d;
    logic [N_OUT-1:0]  onehot_q;
    logic [N_OUT-1:0]  onehot_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              null_pulse_q;
    logic              null_pulse_d;
    logic              timer_load;
    logic              cnt_zero;
    logic              accept;

    code_hold_decoder_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .cnt_zero(cnt_zero)
    );

    // In HOLD the last counted cycle is also an accept window, so a new code
    // can follow the current one with no zero gap on onehot.
    assign in_ready = (state_q == IDLE) || cnt_zero;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        onehot_d     = onehot_q;
        out_valid_d  = out_valid_q;
        null_pulse_d = 1'b0;
        timer_load   = 1'b0;

        if (accept) begin
            if (code[CODE_VALID_BIT]) begin
                state_d     = HOLD;
                onehot_d    = decode_idx(code[IDX_W-1:0]);
                out_valid_d = 1'b1;
                timer_load  = 1'b1;
            end else begin
                state_d      = IDLE;
                onehot_d     = '0;
                out_valid_d  = 1'b0;
                null_pulse_d = 1'b1;
            end
        end else if ((state_q == HOLD) && cnt_zero) begin
            state_d     = IDLE;
            onehot_d    = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            onehot_q     <= '0;
            out_valid_q  <= 1'b0;
            null_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            onehot_q     <= onehot_d;
            out_valid_q  <= out_valid_d;
            null_pulse_q <= null_pulse_d;
        end
    end

    assign onehot     = onehot_q;
    assign out_valid  = out_valid_q;
    assign null_pulse = null_pulse_q;

endmodule

// File: tb/tb_code_hold_decoder.sv
// Bench for code_hold_decoder with HOLD_CYCLES=4: directed scenarios plus
// random traffic, all checked against a cycle-level behavioural model.
module tb_code_hold_decoder;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] code;
    logic [3:0] onehot;
    logic       out_valid;
    logic       null_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: m_rem counts how many more cycles the current
    // one-hot value stays visible; the block is ready when at most one remains.
    int         m_rem    = 0;
    logic [3:0] m_onehot = '0;
    logic       m_null   = 1'b0;

    // Scoreboard of expected {null_pulse, out_valid, onehot}.
    logic [5:0] exp_q[$];

    code_hold_decoder #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .onehot    (onehot),
        .out_valid (out_valid),
        .null_pulse(null_pulse)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem    = 0;
        m_onehot = '0;
        m_null   = 1'b0;
        exp_q.delete();
    endtask

    // 4-input priority encoder producing {valid, idx}.
    function automatic logic [2:0] prio_encode(input logic [3:0] x);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (x[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    // Drive one cycle of input, predict, clock, and compare.
    task automatic step(input logic v, input logic [2:0] c);
        logic       exp_ready;
        logic [5:0] exp_vec;
        in_valid = v;
        code     = c;
        #1;
        exp_ready = (m_rem <= 1);
        check_eq("in_ready", {7'b0, in_ready}, {7'b0, exp_ready});
        if (v && exp_ready) begin
            if (c[2]) begin
                m_onehot = 4'(1 << c[1:0]);
                m_rem    = HOLD;
                m_null   = 1'b0;
            end else begin
                m_onehot = '0;
                m_rem    = 0;
                m_null   = 1'b1;
            end
        end else begin
            m_null = 1'b0;
            if (m_rem > 0) m_rem--;
            if (m_rem == 0) m_onehot = '0;
        end
        exp_q.push_back({m_null, (m_onehot != 0), m_onehot});
        @(posedge clk);
        #1;
        exp_vec = exp_q.pop_front();
        check_eq("outputs", {2'b0, null_pulse, out_valid, onehot}, {2'b0, exp_vec});
    endtask

    initial begin
        int seen_1000;
        int seen_null;
        logic [3:0] enc_in [5];

        rst      = 1'b1;
        in_valid = 1'b0;
        code     = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;

        // 1: reset state
        check_eq("rst_onehot", {4'b0, onehot}, 8'h00);
        check_eq("rst_out_valid", {7'b0, out_valid}, 8'h00);
        check_eq("rst_null_pulse", {7'b0, null_pulse}, 8'h00);
        check_eq("rst_in_ready", {7'b0, in_ready}, 8'h01);
        model_reset();
        step(1'b0, 3'b000);
        step(1'b0, 3'b000);

        // 2: single valid accept, hold length
        seen_1000 = 0;
        step(1'b1, 3'b111);
        if (onehot == 4'b1000) seen_1000++;
        for (int i = 0; i < HOLD + 1; i++) begin
            step(1'b0, 3'b000);
            if (onehot == 4'b1000) seen_1000++;
        end
        check_eq("hold_len", 8'(seen_1000), 8'(HOLD));

        // 3: null accept
        seen_null = 0;
        step(1'b1, 3'b000);
        if (null_pulse) seen_null++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b000);
            if (null_pulse) seen_null++;
        end
        check_eq("null_len", 8'(seen_null), 8'd1);

        // 4: back-to-back valid codes, no gap
        step(1'b1, 3'b111);
        for (int i = 0; i < HOLD + 2; i++) step(1'b1, 3'b101);
        for (int i = 0; i < HOLD + 1; i++) step(1'b0, 3'b000);

        // 5: priority encoder round trip
        enc_in[0] = 4'b0000;
        enc_in[1] = 4'b1000;
        enc_in[2] = 4'b1011;
        enc_in[3] = 4'b0101;
        enc_in[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, prio_encode(enc_in[k]));
            for (int i = 0; i < HOLD; i++) step(1'b0, 3'b000);
        end

        // 6: asynchronous reset mid-hold
        step(1'b1, 3'b111);
        step(1'b1, 3'b111);
        #3 rst = 1'b1;
        #1;
        check_eq("async_onehot", {4'b0, onehot}, 8'h00);
        check_eq("async_out_valid", {7'b0, out_valid}, 8'h00);
        check_eq("async_null_pulse", {7'b0, null_pulse}, 8'h00);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b1, 3'b110);
        for (int i = 0; i < HOLD + 1; i++) step(1'b0, 3'b000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
